// File: rtl/rf_pkg.sv
// rf_pkg: shared sizing defaults and helpers for the parametrised register file
package rf_pkg;
    localparam int RF_DEF_DATA_W = 8;
    localparam int RF_DEF_ADDR_W = 3;

    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    // lsb position of register idx inside the flattened R_all bus
    function automatic int rf_lsb(input int idx, input int data_w);
        return idx * data_w;
    endfunction
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational operand port with bypass, R0 masking and ready
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W  = RF_DEF_DATA_W,
    parameter int ADDR_W  = RF_DEF_ADDR_W,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b0,
    parameter int N       = rf_depth(ADDR_W)
) (
    input  logic [DATA_W*N-1:0] regs_i,
    input  logic [N-1:0]        pend_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic                wr_i,
    input  logic [ADDR_W-1:0]   wa_i,
    input  logic [DATA_W-1:0]   wd_i,
    output logic [DATA_W-1:0]   data_o,
    output logic                rdy_o
);
    logic is_zero;
    logic hit;

    // R0 masking has priority over bypass so a suppressed R0 write never leaks through
    always_comb begin
        is_zero = ZERO_R0 && (addr_i == '0);
        hit     = BYPASS && wr_i && (addr_i == wa_i) && !is_zero;
        data_o  = is_zero ? '0 : hit ? wd_i : regs_i[rf_lsb(int'(addr_i), DATA_W) +: DATA_W];
        rdy_o   = is_zero | hit | ~pend_i[addr_i];
    end
endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised 2-read/1-write register file with pending scoreboard
module reg_file_param
    import rf_pkg::*;
#(
    parameter int DATA_W  = RF_DEF_DATA_W,
    parameter int ADDR_W  = RF_DEF_ADDR_W,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 WR,
    input  logic [ADDR_W-1:0]                    DA,
    input  logic [DATA_W-1:0]                    D,
    input  logic [ADDR_W-1:0]                    AA,
    input  logic [ADDR_W-1:0]                    BA,
    input  logic                                 PS,
    input  logic [ADDR_W-1:0]                    PA,
    output logic [DATA_W-1:0]                    A,
    output logic [DATA_W-1:0]                    B,
    output logic                                 A_rdy,
    output logic                                 B_rdy,
    output logic [rf_depth(ADDR_W)-1:0]          pend,
    output logic [DATA_W*rf_depth(ADDR_W)-1:0]   R_all
);
    localparam int N = rf_depth(ADDR_W);

    logic [DATA_W-1:0] regs_q [N];
    logic [N-1:0]      pend_q;
    logic [N-1:0]      pend_d;
    logic              wr_en;
    logic              ps_en;

    // the set is applied after the clear so a same-address collision stays pending
    always_comb begin
        wr_en  = WR && !(ZERO_R0 && (DA == '0));
        ps_en  = PS && !(ZERO_R0 && (PA == '0));
        pend_d = pend_q;
        if (wr_en) pend_d[DA] = 1'b0;
        if (ps_en) pend_d[PA] = 1'b1;
    end

    // storage array and scoreboard, both cleared immediately by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) regs_q[i] <= '0;
            pend_q <= '0;
        end else begin
            if (wr_en) regs_q[DA] <= D;
            pend_q <= pend_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign R_all[g*DATA_W +: DATA_W] = regs_q[g];
    end
    assign pend = pend_q;

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)) u_a (
        .regs_i(R_all), .pend_i(pend_q), .addr_i(AA), .wr_i(WR), .wa_i(DA), .wd_i(D),
        .data_o(A), .rdy_o(A_rdy)
    );

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)) u_b (
        .regs_i(R_all), .pend_i(pend_q), .addr_i(BA), .wr_i(WR), .wa_i(DA), .wd_i(D),
        .data_o(B), .rdy_o(B_rdy)
    );
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: three configurations against one behavioural register-file model
module tb_reg_file_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr = 1'b0, ps = 1'b0;
    logic [3:0]  da = '0, aa = '0, ba = '0, pa = '0;
    logic [15:0] d = '0;

    always #5 clk = ~clk;

    // instance 0: 8x8 bypass; 1: 8x8 no bypass + zero R0; 2: 16x16 bypass + zero R0
    logic [7:0]   a0, b0, a1, b1;
    logic [15:0]  a2, b2;
    logic         ar0, br0, ar1, br1, ar2, br2;
    logic [7:0]   p0, p1;
    logic [15:0]  p2;
    logic [63:0]  r0, r1;
    logic [255:0] r2;

    reg_file_param #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_R0(0)) u0 (
        .clock(clk), .reset(rst_n), .WR(wr), .DA(da[2:0]), .D(d[7:0]), .AA(aa[2:0]), .BA(ba[2:0]),
        .PS(ps), .PA(pa[2:0]), .A(a0), .B(b0), .A_rdy(ar0), .B_rdy(br0), .pend(p0), .R_all(r0));
    reg_file_param #(.DATA_W(8), .ADDR_W(3), .BYPASS(0), .ZERO_R0(1)) u1 (
        .clock(clk), .reset(rst_n), .WR(wr), .DA(da[2:0]), .D(d[7:0]), .AA(aa[2:0]), .BA(ba[2:0]),
        .PS(ps), .PA(pa[2:0]), .A(a1), .B(b1), .A_rdy(ar1), .B_rdy(br1), .pend(p1), .R_all(r1));
    reg_file_param #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .ZERO_R0(1)) u2 (
        .clock(clk), .reset(rst_n), .WR(wr), .DA(da), .D(d), .AA(aa), .BA(ba),
        .PS(ps), .PA(pa), .A(a2), .B(b2), .A_rdy(ar2), .B_rdy(br2), .pend(p2), .R_all(r2));

    logic [15:0]  ga [3], gb [3], gp [3];
    logic         gar [3], gbr [3];
    logic [255:0] gr [3];
    assign ga[0] = {8'h0, a0};  assign ga[1] = {8'h0, a1};  assign ga[2] = a2;
    assign gb[0] = {8'h0, b0};  assign gb[1] = {8'h0, b1};  assign gb[2] = b2;
    assign gp[0] = {8'h0, p0};  assign gp[1] = {8'h0, p1};  assign gp[2] = p2;
    assign gar[0] = ar0; assign gar[1] = ar1; assign gar[2] = ar2;
    assign gbr[0] = br0; assign gbr[1] = br1; assign gbr[2] = br2;
    assign gr[0] = {192'h0, r0}; assign gr[1] = {192'h0, r1}; assign gr[2] = r2;

    int cfg_dw [3] = '{8, 8, 16};
    int cfg_aw [3] = '{3, 3, 4};
    bit cfg_by [3] = '{1'b1, 1'b0, 1'b1};
    bit cfg_z  [3] = '{1'b0, 1'b1, 1'b1};

    logic [15:0] mem [3][16];
    logic [15:0] pnd [3];
    int nvec = 0, nerr = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mclear();
        for (int k = 0; k < 3; k++) begin
            pnd[k] = '0;
            for (int i = 0; i < 16; i++) mem[k][i] = '0;
        end
    endtask

    function automatic logic [3:0] am(input int k);
        return 4'((1 << cfg_aw[k]) - 1);
    endfunction

    function automatic logic [15:0] dm(input int k);
        return cfg_dw[k] == 16 ? 16'hFFFF : 16'h00FF;
    endfunction

    // what a read port must show for address a of configuration k
    task automatic mread(input int k, input logic [3:0] a_in, output logic [15:0] dv, output logic rv);
        logic [3:0] a = a_in & am(k);
        logic [3:0] w = da & am(k);
        if (cfg_z[k] && a == 0) begin dv = 0; rv = 1; end
        else if (cfg_by[k] && wr && a == w) begin dv = d & dm(k); rv = 1; end
        else begin dv = mem[k][a]; rv = !pnd[k][a]; end
    endtask

    // clock edge: write clears pending, then the pending set wins
    task automatic mupd();
        if (!rst_n) return;
        for (int k = 0; k < 3; k++) begin
            logic [3:0] w = da & am(k);
            logic [3:0] p = pa & am(k);
            if (wr && !(cfg_z[k] && w == 0)) begin mem[k][w] = d & dm(k); pnd[k][w] = 1'b0; end
            if (ps && !(cfg_z[k] && p == 0)) pnd[k][p] = 1'b1;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            logic [15:0] ed;
            logic er;
            logic [255:0] rall = '0;
            mread(k, aa, ed, er);
            check($sformatf("u%0d.A", k), 256'(ga[k]), 256'(ed));
            check($sformatf("u%0d.A_rdy", k), 256'(gar[k]), 256'(er));
            mread(k, ba, ed, er);
            check($sformatf("u%0d.B", k), 256'(gb[k]), 256'(ed));
            check($sformatf("u%0d.B_rdy", k), 256'(gbr[k]), 256'(er));
            check($sformatf("u%0d.pend", k), 256'(gp[k]), 256'(pnd[k]));
            for (int i = 0; i < (1 << cfg_aw[k]); i++) rall |= 256'(mem[k][i]) << (i * cfg_dw[k]);
            check($sformatf("u%0d.R_all", k), gr[k], rall);
        end
    endtask

    task automatic set_in(input logic w, input logic [3:0] wa, input logic [15:0] wd,
                          input logic [3:0] ra, input logic [3:0] rb, input logic s, input logic [3:0] sa);
        wr = w; da = wa; d = wd; aa = ra; ba = rb; ps = s; pa = sa;
    endtask

    task automatic settle();
        #2 compare_all();
    endtask

    task automatic adv();
        @(posedge clk);
        mupd();
        #1;
    endtask

    initial begin
        mclear();
        @(posedge clk);
        #1 rst_n = 1'b1;
        settle();
        check("reset A_rdy", 256'(ar0), 256'(1));
        adv();
        // preload every register and some pending bits, then reset mid-cycle
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, 4'(i), 16'($urandom) | 16'h0101, 4'($urandom), 4'($urandom), 1'b1, 4'(i + 3));
            settle();
            adv();
        end
        set_in(1'b0, 4'd5, 16'h0, 4'd5, 4'd6, 1'b0, 4'd0);
        settle();
        check("preload R_all nonzero", 256'(r0 != 0), 256'(1));
        #1 rst_n = 1'b0;
        #1 mclear();
        compare_all();
        check("async reset R_all", 256'(r2), 256'(0));
        check("async reset pend", 256'(p0), 256'(0));
        check("async reset A_rdy", 256'({ar0, ar1, ar2, br0, br1, br2}), 256'(6'h3F));
        adv();
        compare_all();
        rst_n = 1'b1;
        settle();
        adv();
        // write then read, bypass vs stored
        set_in(1'b1, 4'd5, 16'h12A7, 4'd5, 4'd0, 1'b0, 4'd0);
        settle();
        check("bypass A", 256'(a0), 256'(8'hA7));
        check("nobypass old A", 256'(a1), 256'(8'h00));
        adv();
        set_in(1'b0, 4'd5, 16'h0, 4'd5, 4'd0, 1'b0, 4'd0);
        settle();
        check("stored A", 256'(a1), 256'(8'hA7));
        check("stored A16", 256'(a2), 256'(16'h12A7));
        // scoreboard set then clear by write
        set_in(1'b0, 4'd0, 16'h0, 4'd0, 4'd3, 1'b1, 4'd3);
        settle();
        adv();
        set_in(1'b0, 4'd0, 16'h0, 4'd0, 4'd3, 1'b0, 4'd0);
        settle();
        check("pend[3] set", 256'(p0[3]), 256'(1));
        check("B_rdy pending", 256'(br0), 256'(0));
        set_in(1'b1, 4'd3, 16'h003C, 4'd0, 4'd3, 1'b0, 4'd0);
        settle();
        check("B_rdy bypass", 256'(br0), 256'(1));
        check("B bypass", 256'(b0), 256'(8'h3C));
        check("B_rdy nobypass", 256'(br1), 256'(0));
        adv();
        set_in(1'b0, 4'd0, 16'h0, 4'd0, 4'd3, 1'b0, 4'd0);
        settle();
        check("B_rdy cleared", 256'(br1), 256'(1));
        check("B stored", 256'(b1), 256'(8'h3C));
        // collision of write and pending set
        set_in(1'b1, 4'd2, 16'h0011, 4'd2, 4'd2, 1'b1, 4'd2);
        settle();
        adv();
        set_in(1'b0, 4'd0, 16'h0, 4'd2, 4'd2, 1'b0, 4'd0);
        settle();
        check("collision reg", 256'(r0[23:16]), 256'(8'h11));
        check("collision pend", 256'(p0[2]), 256'(1));
        // R0 hardwired zero
        set_in(1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 1'b1, 4'd0);
        settle();
        check("R0 A", 256'(a2), 256'(0));
        check("R0 A_rdy", 256'(ar1), 256'(1));
        adv();
        set_in(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 4'd0);
        settle();
        check("R0 pend", 256'(p1[0]), 256'(0));
        check("R0 slice", 256'(r1[7:0]), 256'(0));
        // top register of the wide configuration
        set_in(1'b1, 4'd15, 16'hBEEF, 4'd15, 4'd0, 1'b0, 4'd0);
        settle();
        adv();
        set_in(1'b0, 4'd0, 16'h0, 4'd15, 4'd15, 1'b0, 4'd0);
        settle();
        check("R_all top slice", 256'(r2[255:240]), 256'(16'hBEEF));
        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            set_in(1'($urandom_range(0, 99) < 60), 4'($urandom), 16'($urandom),
                   4'($urandom), 4'($urandom), 1'($urandom_range(0, 99) < 30), 4'($urandom));
            if ($urandom_range(0, 9) == 0) aa = da;
            if ($urandom_range(0, 9) == 0) ba = aa;
            settle();
            adv();
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
